// File: rtl/clk_div_pkg.sv
// Shared definitions for the divide-by-N clock divider and its checker.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    MEASURE,
    LOCKED
  } mon_state_t;

  localparam int DIV_N_DEF = 7;

  function automatic int duty_lo(input int n);
    return n / 2;
  endfunction

  function automatic int duty_hi(input int n);
    return (n + 1) / 2;
  endfunction

  localparam int DUTY_LO = duty_lo(DIV_N_DEF);
  localparam int DUTY_HI = duty_hi(DIV_N_DEF);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, async active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Period / high-phase checker for a divided clock, sampled in clk domain.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int DIV_N    = DIV_N_DEF,
  parameter int CNT_W    = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_div_clk,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_err_period,
  output logic             o_err_duty
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] DIV_T = CNT_W'(DIV_N);
  localparam logic [CNT_W-1:0] LO_T  = CNT_W'(duty_lo(DIV_N));
  localparam logic [CNT_W-1:0] HI_T  = CNT_W'(duty_hi(DIV_N));
  localparam logic [CNT_W-1:0] MAX_T = '1;
  localparam logic [GW-1:0]    LAST_G = GW'(LOCK_CNT - 1);

  logic div_s;
  logic div_h;
  logic rise;
  logic fall;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_div_clk),
    .q     (div_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_h <= 1'b0;
    else       div_h <= div_s;
  end

  assign rise = div_s & ~div_h;
  assign fall = ~div_s & div_h;

  mon_state_t       state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [GW-1:0]    good_cnt;
  logic [CNT_W-1:0] per_inc;
  logic             per_ok;
  logic             duty_ok;
  logic             tmo;

  assign per_inc = per_cnt + CNT_W'(1);
  assign per_ok  = (per_inc == DIV_T);
  assign duty_ok = (high_cnt == LO_T) || (high_cnt == HI_T);
  assign tmo     = (per_inc == MAX_T);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      per_cnt        <= '0;
      high_cnt       <= '0;
      good_cnt       <= '0;
      o_period       <= '0;
      o_high         <= '0;
      o_period_valid <= 1'b0;
      o_locked       <= 1'b0;
      o_err_period   <= 1'b0;
      o_err_duty     <= 1'b0;
    end else if (!i_en) begin
      state          <= IDLE;
      per_cnt        <= '0;
      high_cnt       <= '0;
      good_cnt       <= '0;
      o_period_valid <= 1'b0;
      o_locked       <= 1'b0;
    end else begin
      o_period_valid <= 1'b0;
      unique case (state)
        IDLE: state <= ALIGN;
        ALIGN: begin
          if (rise) begin
            state    <= MEASURE;
            per_cnt  <= '0;
            high_cnt <= '0;
          end
        end
        default: begin
          if (rise) begin
            o_period       <= per_inc;
            o_high         <= high_cnt;
            o_period_valid <= 1'b1;
            per_cnt        <= '0;
            high_cnt       <= '0;
            if (per_ok && duty_ok) begin
              if (state == MEASURE) begin
                if (good_cnt == LAST_G) begin
                  state    <= LOCKED;
                  o_locked <= 1'b1;
                end else begin
                  good_cnt <= good_cnt + GW'(1);
                end
              end
            end else begin
              state        <= MEASURE;
              good_cnt     <= '0;
              o_locked     <= 1'b0;
              o_err_period <= o_err_period | ~per_ok;
              o_err_duty   <= o_err_duty | ~duty_ok;
            end
          end else if (tmo) begin
            // saturate and realign; the next rise restarts a clean period
            state        <= ALIGN;
            per_cnt      <= MAX_T;
            good_cnt     <= '0;
            o_locked     <= 1'b0;
            o_err_period <= 1'b1;
          end else begin
            per_cnt <= per_inc;
            if (fall) high_cnt <= per_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized bench for clk_div_monitor against a waveform-level model.
module tb_clk_div_monitor;

  localparam int DIV   = 7;
  localparam int TMO   = 15;
  localparam int LOCKN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_en = 1'b1;
  logic       i_div_clk = 1'b0;
  logic [3:0] o_period;
  logic [3:0] o_high;
  logic       o_period_valid;
  logic       o_locked;
  logic       o_err_period;
  logic       o_err_duty;

  clk_div_monitor #(
    .DIV_N    (DIV),
    .CNT_W    (4),
    .LOCK_CNT (LOCKN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_en           (i_en),
    .i_div_clk      (i_div_clk),
    .o_period       (o_period),
    .o_high         (o_high),
    .o_period_valid (o_period_valid),
    .o_locked       (o_locked),
    .o_err_period   (o_err_period),
    .o_err_duty     (o_err_duty)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int p;
    int h;
    bit ep;
    bit ed;
    bit lk;
  } exp_t;

  exp_t q[$];
  bit   cur = 0;
  bit   armed = 0;
  bit   en_m = 1;
  bit   ep = 0;
  bit   ed = 0;
  bit   lk = 0;
  int   streak = 0;
  int   cur_p = 0;
  int   cur_h = 0;
  int   last_p = 0;

  task automatic judge(input int p, input int h);
    exp_t e;
    bit h_ok;
    h_ok = (h == DIV / 2) || (h == (DIV + 1) / 2);
    if (p > TMO) begin
      ep = 1;
      streak = 0;
      lk = 0;
    end else begin
      if (p == DIV && h_ok) begin
        streak++;
        if (streak >= LOCKN) lk = 1;
      end else begin
        streak = 0;
        lk = 0;
        if (p != DIV) ep = 1;
        if (!h_ok) ed = 1;
      end
      e.p = p;
      e.h = h;
      e.ep = ep;
      e.ed = ed;
      e.lk = lk;
      q.push_back(e);
      last_p = p;
    end
  endtask

  task automatic phase(input bit lvl, input int n);
    if (lvl && !cur) begin
      if (armed) judge(cur_p, cur_h);
      armed = en_m;
      cur_p = 0;
      cur_h = 0;
    end
    cur = lvl;
    i_div_clk = lvl;
    cur_p += n;
    if (lvl) cur_h += n;
    repeat (n) @(negedge clk);
  endtask

  task automatic per(input int h, input int l);
    phase(1'b1, h);
    phase(1'b0, l);
  endtask

  task automatic set_en(input bit v);
    i_en = v;
    en_m = v;
    if (!v) begin
      armed = 0;
      streak = 0;
      lk = 0;
    end
  endtask

  int cyc = 0;
  int last_valid_cyc = 0;
  int fall_cyc = -1;
  bit prev_lk = 0;
  bit ep_at_fall = 0;
  bit en_s = 0;
  int bad_valid = 0;

  always @(posedge clk) en_s <= i_en;

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (o_period_valid) begin
      last_valid_cyc = cyc;
      if (!en_s) bad_valid++;
      if (q.size() == 0) begin
        chk("valid_has_expect", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("period", int'(o_period), e.p);
        chk("high", int'(o_high), e.h);
        chk("locked", int'(o_locked), int'(e.lk));
        chk("err_period", int'(o_err_period), int'(e.ep));
        chk("err_duty", int'(o_err_duty), int'(e.ed));
      end
    end
    if (prev_lk && !o_locked) begin
      fall_cyc = cyc;
      ep_at_fall = o_err_period;
    end
    prev_lk = o_locked;
  end

  initial begin
    int r;
    int h;
    @(negedge clk);
    #2;
    chk("rst_period", int'(o_period), 0);
    chk("rst_high", int'(o_high), 0);
    chk("rst_valid", int'(o_period_valid), 0);
    chk("rst_locked", int'(o_locked), 0);
    chk("rst_err_period", int'(o_err_period), 0);
    chk("rst_err_duty", int'(o_err_duty), 0);
    @(negedge clk);
    reset = 1'b0;

    repeat (6) per(4, 3);
    repeat (6) per(3, 4);

    chk("pre_tmo_locked", int'(o_locked), 1);
    chk("pre_tmo_err", int'(o_err_period), 0);
    per(4, 3);
    phase(1'b0, 30);
    chk("tmo_delay", fall_cyc - last_valid_cyc, TMO);
    chk("tmo_err", int'(ep_at_fall), 1);
    repeat (6) per(4, 3);

    per(5, 2);
    repeat (5) per(4, 3);
    per(4, 4);
    repeat (6) per(4, 3);

    phase(1'b1, 4);
    phase(1'b0, 1);
    set_en(1'b0);
    phase(1'b0, 2);
    chk("dis_locked", int'(o_locked), 0);
    chk("dis_hold_period", int'(o_period), last_p);
    phase(1'b1, 4);
    phase(1'b0, 4);
    set_en(1'b1);
    phase(1'b0, 4);
    repeat (6) per(4, 3);
    chk("no_valid_while_off", bad_valid, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        h = $urandom_range(3, 4);
        per(h, DIV - h);
      end else if (r < 9) begin
        per($urandom_range(1, 6), $urandom_range(1, 9));
      end else begin
        per(4, 12 + $urandom_range(0, 3));
      end
    end
    per(4, 11);
    repeat (6) per(4, 3);

    phase(1'b1, 5);
    phase(1'b0, 1);
    chk("pre_rst_err_period", int'(o_err_period), int'(ep));
    chk("pre_rst_err_duty", int'(o_err_duty), int'(ed));
    #2 reset = 1'b1;
    #1;
    chk("arst_period", int'(o_period), 0);
    chk("arst_high", int'(o_high), 0);
    chk("arst_locked", int'(o_locked), 0);
    chk("arst_err_period", int'(o_err_period), 0);
    chk("arst_err_duty", int'(o_err_duty), 0);
    ep = 0;
    ed = 0;
    lk = 0;
    streak = 0;
    armed = 0;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    phase(1'b0, 4);
    repeat (6) per(4, 3);
    chk("reacq_locked", int'(o_locked), 1);

    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
